instr_fetch_unit: RTL and testbench

//  Instruction fetch stage for the MIPS core: owns the PC, issues word reads to

---
 rtl/instr_fetch_unit.sv | 129 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - MIPS instruction fetch stage with 2-entry output buffer and redirect flush
// Optional feature macro: IFU_PERF_CNT_EN (adds perf_fetched / perf_stall counters)
module instr_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic [ADDR_W-1:0] out_pc_plus4,
    output logic [5:0]        out_opcode,
`ifdef IFU_PERF_CNT_EN
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall,
`endif
    output logic [5:0]        out_funct
);

    logic [ADDR_W-1:0] pc;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_pc;
    logic              kill;
    logic [31:0]       buf_instr [2];
    logic [ADDR_W-1:0] buf_pc    [2];
    logic              head;
    logic [1:0]        count;

    logic              pop;
    logic              push;
    logic              wr_idx;
    logic [2:0]        occupancy;
    logic [ADDR_W-1:0] target_pc;

    // Handshake, push and request decisions for the current cycle
    always_comb begin
        out_valid = (count != 2'd0);
        pop       = out_valid & out_ready;
        // The returning word is dropped if a redirect lands in the same cycle
        push      = inflight & ~kill & ~redirect_valid;
        wr_idx    = head ^ count[0];
        occupancy = {1'b0, count} + {2'b00, inflight};
        // Only request when the word returning next cycle is guaranteed a free slot
        imem_req  = rst_n & ~redirect_valid & (occupancy < (3'd2 + {2'b00, pop}));
        imem_addr = pc;
        target_pc = {redirect_pc[ADDR_W-1:2], redirect_pc[1:0] & 2'b00};
    end

    // PC, inflight tracking and buffer occupancy; redirect overrides normal flow
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            kill        <= 1'b0;
            count       <= 2'd0;
            head        <= 1'b0;
        end else if (redirect_valid) begin
            pc       <= target_pc;
            inflight <= 1'b0;
            kill     <= inflight;
            count    <= 2'd0;
            head     <= 1'b0;
        end else begin
            if (imem_req) begin
                pc          <= pc + ADDR_W'(4);
                inflight_pc <= pc;
            end
            inflight <= imem_req;
            kill     <= 1'b0;
            head     <= head ^ pop;
            count    <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Buffer storage; data needs no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr[wr_idx] <= imem_rdata;
            buf_pc[wr_idx]    <= inflight_pc;
        end
    end

    // Overflow would mean the request rule is broken
    always_ff @(posedge clk) begin
        if (rst_n && push && !pop) begin
            assert (count != 2'd2);
        end
    end

    // Output fields read zero while the buffer is empty
    always_comb begin
        out_instr    = '0;
        out_pc       = '0;
        out_pc_plus4 = '0;
        if (out_valid) begin
            out_instr    = buf_instr[head];
            out_pc       = buf_pc[head];
            out_pc_plus4 = buf_pc[head] + ADDR_W'(4);
        end
        out_opcode = out_instr[31:26];
        out_funct  = out_instr[5:0];
    end

`ifdef IFU_PERF_CNT_EN
    // Fetched-word and decode-stall counters, free-running with wrap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (push) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (out_valid && !out_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        out_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        imem_req, out_valid;
    logic [31:0] imem_addr, imem_rdata, out_instr, out_pc, out_pc_plus4;
    logic [5:0]  out_opcode, out_funct;

    logic        imem_req1, out_valid1;
    logic [31:0] imem_addr1, imem_rdata1, out_instr1, out_pc1, out_pc_plus41;
    logic [5:0]  out_opcode1, out_funct1;
    logic        out_ready1 = 1'b1;
    logic        redirect_valid1 = 1'b0;
    logic [31:0] redirect_pc1 = 32'h0;

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stall, perf_fetched1, perf_stall1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_pc_plus4(out_pc_plus4),
        .out_opcode(out_opcode),
`ifdef IFU_PERF_CNT_EN
        .perf_fetched(perf_fetched), .perf_stall(perf_stall),
`endif
        .out_funct(out_funct)
    );

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req1), .imem_addr(imem_addr1), .imem_rdata(imem_rdata1),
        .redirect_valid(redirect_valid1), .redirect_pc(redirect_pc1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_instr(out_instr1), .out_pc(out_pc1), .out_pc_plus4(out_pc_plus41),
        .out_opcode(out_opcode1),
`ifdef IFU_PERF_CNT_EN
        .perf_fetched(perf_fetched1), .perf_stall(perf_stall1),
`endif
        .out_funct(out_funct1)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a << 8) | 32'h0000_0020;
    endfunction

    // Instruction memory: one-cycle read latency
    always @(posedge clk) begin
        if (imem_req)  imem_rdata  <= word_at(imem_addr);
        if (imem_req1) imem_rdata1 <= word_at(imem_addr1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (2) @(posedge clk);

        @(negedge clk); #1;
        chk("reset_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_req",   {31'b0, imem_req},  32'd0);
        chk("reset_instr", out_instr, 32'h0);
        chk("reset_pc",    out_pc,    32'h0);

        @(negedge clk); rst_n = 1'b1; #1;
        chk("first_req",       {31'b0, imem_req}, 32'd1);
        chk("first_addr",      imem_addr,  32'h0);
        chk("wrap_first_addr", imem_addr1, 32'hFFFF_FFF8);

        @(negedge clk); #1;
        chk("lat_valid", {31'b0, out_valid}, 32'd0);
        chk("lat_addr",  imem_addr, 32'h4);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            chk("stream_valid", {31'b0, out_valid}, 32'd1);
            chk("stream_pc",    out_pc, 32'(4 * i));
            chk("stream_instr", out_instr, word_at(32'(4 * i)));
            if (i == 0) begin
                chk("first_opcode", {26'b0, out_opcode}, 32'h0);
                chk("first_funct",  {26'b0, out_funct},  32'h20);
                chk("first_plus4",  out_pc_plus4, 32'h4);
            end
            if (i < 3) begin
                chk("wrap_valid", {31'b0, out_valid1}, 32'd1);
                chk("wrap_pc",    out_pc1, 32'hFFFF_FFF8 + 32'(4 * i));
            end
            if (i == 1) chk("wrap_plus4", out_pc_plus41, 32'h0);
        end

        for (int i = 0; i < 5; i++) begin
            @(negedge clk); out_ready = 1'b0; #1;
            chk("stall_valid", {31'b0, out_valid}, 32'd1);
            chk("stall_pc",    out_pc, 32'h20);
            chk("stall_instr", out_instr, word_at(32'h20));
            chk("stall_req",   {31'b0, imem_req}, 32'd0);
        end

        for (int i = 0; i < 4; i++) begin
            @(negedge clk); out_ready = 1'b1; #1;
            chk("resume_valid", {31'b0, out_valid}, 32'd1);
            chk("resume_pc",    out_pc, 32'h20 + 32'(4 * i));
        end

        @(negedge clk); out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; #1;
        chk("redir_req",    {31'b0, imem_req}, 32'd0);
        chk("redir_pc_vis", out_pc, 32'h30);

        @(negedge clk); redirect_valid = 1'b0; out_ready = 1'b1; #1;
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        chk("target_req",  {31'b0, imem_req}, 32'd1);
        chk("target_addr", imem_addr, 32'h100);
`ifdef IFU_PERF_CNT_EN
        chk("perf_stall",   perf_stall,   32'd6);
        chk("perf_fetched", perf_fetched, 32'd13);
`endif

        @(negedge clk); #1;
        chk("flush_valid2", {31'b0, out_valid}, 32'd0);
        chk("target_addr2", imem_addr, 32'h104);

        @(negedge clk); #1;
        chk("target_valid", {31'b0, out_valid}, 32'd1);
        chk("target_pc",    out_pc, 32'h100);
        chk("target_instr", out_instr, word_at(32'h100));
        chk("target_plus4", out_pc_plus4, 32'h104);

        @(negedge clk); #1;
        chk("target_pc2", out_pc, 32'h104);

        @(negedge clk); rst_n = 1'b0; #1;
        chk("midrst_req", {31'b0, imem_req}, 32'd0);

        @(negedge clk); rst_n = 1'b1; #1;
        chk("midrst_valid", {31'b0, out_valid}, 32'd0);
        chk("refetch_req",  {31'b0, imem_req}, 32'd1);
        chk("refetch_addr", imem_addr, 32'h0);
`ifdef IFU_PERF_CNT_EN
        chk("rst_perf_fetched", perf_fetched, 32'd0);
        chk("rst_perf_stall",   perf_stall,   32'd0);
`endif

        @(negedge clk); #1;
        chk("refetch_valid0", {31'b0, out_valid}, 32'd0);

        @(negedge clk); #1;
        chk("refetch_valid", {31'b0, out_valid}, 32'd1);
        chk("refetch_pc",    out_pc, 32'h0);
        chk("refetch_instr", out_instr, word_at(32'h0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
